// File: rtl/alu_op_sequencer_if.sv
// Bundles the command, ALU-unit and response signals of alu_op_sequencer.
//   cmd_*            : valid/ready command port (controller -> sequencer)
//   A, B, ALU_FUN,
//   *_Enable         : operand buses, function code and one-hot unit enables (sequencer -> units)
//   unit_out/flag    : OR of unit result and flag registers (units -> sequencer)
//   rsp_*            : valid/ready response port (sequencer -> controller)
// Modports: master = sequencer view, slave = controller/units view.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_fun;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ALU_FUN;
  logic             Arith_Enable;
  logic             Logic_Enable;
  logic             CMP_Enable;
  logic             Shift_Enable;
  logic [WIDTH-1:0] unit_out;
  logic             unit_flag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b, unit_out, unit_flag, rsp_ready,
    output cmd_ready, A, B, ALU_FUN, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
           rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_fun, cmd_a, cmd_b, unit_out, unit_flag, rsp_ready,
    input  cmd_ready, A, B, ALU_FUN, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
           rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the signed ALU datapath. Takes one command at a time, issues it to
// the unit selected by cmd_fun[3:2] for one cycle, waits for the unit flag, and returns the
// captured result on the response port.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_op_sequencer_if.master (command, unit and response signals)
// Optional feature: define ALU_SEQ_TIMEOUT_EN to abort after TIMEOUT wait cycles with rsp_err=1.
module alu_op_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 8
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.master bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       fun_q, fun_d;
  logic [3:0]       en_q, en_d;  // {shift, cmp, logic, arith}
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;
  // cnt_q counts completed wait cycles minus one, so the TIMEOUT-th wait cycle aborts.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    en_d        = 4'b0000;  // enables are only ever high for the single ISSUE cycle
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          fun_d   = bus.cmd_fun[1:0];
          en_d    = 4'b0001 << bus.cmd_fun[3:2];
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (bus.unit_flag) begin
          rsp_data_d  = bus.unit_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      en_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready    = (state_q == StIdle);
  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.ALU_FUN      = fun_q;
  assign bus.Arith_Enable = en_q[0];
  assign bus.Logic_Enable = en_q[1];
  assign bus.CMP_Enable   = en_q[2];
  assign bus.Shift_Enable = en_q[3];
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered logic-unit model attached.
module tb_alu_op_sequencer;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Logic unit: AND/OR/NAND/NOR, result and flag registered one edge after its enable.
  logic [WIDTH-1:0] uout_q;
  logic             uflag_q;
  logic             mute = 1'b0;
  logic             stray = 1'b0;
  always @(posedge clk) begin
    if (rst || !bus.Logic_Enable || mute) begin
      uout_q  <= '0;
      uflag_q <= 1'b0;
    end else begin
      uflag_q <= 1'b1;
      case (bus.ALU_FUN)
        2'b00:   uout_q <= bus.A & bus.B;
        2'b01:   uout_q <= bus.A | bus.B;
        2'b10:   uout_q <= ~(bus.A & bus.B);
        default: uout_q <= ~(bus.A | bus.B);
      endcase
    end
  end
  assign bus.unit_out  = uout_q;
  assign bus.unit_flag = uflag_q | stray;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ens();
    return {bus.Shift_Enable, bus.CMP_Enable, bus.Logic_Enable, bus.Arith_Enable};
  endfunction

  // Drives a command and returns #1 after its accept edge.
  task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    bus.cmd_fun   = f;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", {31'b0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  logic [15:0] got [2];
  int          acc_cyc [2];
  int          n_acc, n_rsp, n, pulses, hits;
  logic        will_acc, will_rsp;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_fun   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("rst_en", {28'b0, ens()}, 32'h0);
    check("rst_ab", {bus.A, bus.B}, 32'h0);
    check("rst_rsp", {13'b0, bus.ALU_FUN, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'h0);

    // Stray flag in IDLE must be ignored.
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    check("stray_idle_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("stray_idle_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

    // Logic AND
    send(4'b0100, 16'hF0F0, 16'hFF00);
    check("and_issue_en", {28'b0, ens()}, 32'b0010);
    check("and_issue_fun", {30'b0, bus.ALU_FUN}, 32'd0);
    check("and_issue_ab", {bus.A, bus.B}, 32'hF0F0FF00);
    check("and_issue_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    tick();
    check("and_wait_en", {28'b0, ens()}, 32'h0);
    check("and_wait_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("and_wait_ab_hold", {bus.A, bus.B}, 32'hF0F0FF00);
    tick();
    check("and_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    check("and_rsp_data", {16'b0, bus.rsp_data}, 32'hF000);
    check("and_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    tick();
    check("and_done_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("and_done_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

    // Back-pressure
    bus.rsp_ready = 1'b0;
    send(4'b0100, 16'hF0F0, 16'hFF00);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("bp_rsp_data", {16'b0, bus.rsp_data}, 32'hF000);
      check("bp_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
      tick();
    end
    check("bp_rsp_valid_last", {31'b0, bus.rsp_valid}, 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_done_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("bp_done_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

    // Back-to-back NOR then NAND with cmd_valid held high
    bus.cmd_fun   = 4'b0111;
    bus.cmd_a     = 16'h00FF;
    bus.cmd_b     = 16'h0F00;
    bus.cmd_valid = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    for (int i = 0; i < 24 && n_rsp < 2; i++) begin
      will_acc = bus.cmd_valid && bus.cmd_ready;
      will_rsp = bus.rsp_valid && bus.rsp_ready;
      if (will_rsp) got[n_rsp] = bus.rsp_data;
      tick();
      if (will_acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          bus.cmd_fun = 4'b0110;
          bus.cmd_a   = 16'hFFFF;
          bus.cmd_b   = 16'h00FF;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (will_rsp) n_rsp++;
    end
    bus.cmd_valid = 1'b0;
    check("b2b_n_acc", n_acc, 32'd2);
    check("b2b_n_rsp", n_rsp, 32'd2);
    check("b2b_rsp0", {16'b0, got[0]}, 32'hF000);
    check("b2b_rsp1", {16'b0, got[1]}, 32'hFF00);
    check("b2b_acc_spacing", acc_cyc[1] - acc_cyc[0], 32'd4);

    // Compare command with no unit responding
    send(4'b1000, 16'h0001, 16'h0002);
    check("cmp_issue_en", {28'b0, ens()}, 32'b0100);
    n = 0;
    pulses = 0;
`ifdef ALU_SEQ_TIMEOUT_EN
    while (!bus.rsp_valid && n < 30) begin
      tick();
      n++;
      if (bus.CMP_Enable) pulses++;
    end
    check("to_latency", n, 32'd9);
    check("to_extra_pulses", pulses, 32'd0);
    check("to_rsp_err", {31'b0, bus.rsp_err}, 32'd1);
    check("to_rsp_data", {16'b0, bus.rsp_data}, 32'h0);
    tick();
    check("to_done_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.CMP_Enable) pulses++;
      if (bus.rsp_valid) n++;
    end
    check("nto_rsp_valid_cnt", n, 32'd0);
    check("nto_extra_pulses", pulses, 32'd0);
    check("nto_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    // Reset while waiting on a muted unit
    mute = 1'b1;
    send(4'b0100, 16'hAAAA, 16'h5555);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mrst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("mrst_en", {28'b0, ens()}, 32'h0);
    check("mrst_ab", {bus.A, bus.B}, 32'h0);
    check("mrst_rsp", {13'b0, bus.ALU_FUN, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'h0);
    rst  = 1'b0;
    mute = 1'b0;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rsp_valid) hits++;
    end
    check("mrst_no_rsp", hits, 32'd0);
    send(4'b0101, 16'h1234, 16'h8001);
    tick();
    tick();
    check("post_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    check("post_rst_rsp_data", {16'b0, bus.rsp_data}, 32'h9235);
    tick();
    check("post_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side initiator for the 16-bit signed ALU datapath. Accepts one operation request at a time over a valid/ready command port. Decodes the request into one unit enable and a 2-bit function code, and drives the operand buses for exactly one cycle. It then waits for the selected unit's registered flag, captures the result, and returns it over a valid/ready response port. It sits between the system-side controller and the ALU's execution units: arithmetic, logic, compare and shift.

## Interface
- WIDTH, 16: operand/result width.
- TIMEOUT, 8: maximum number of WAIT cycles before the operation is aborted. Used only when ALU_SEQ_TIMEOUT_EN is defined.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_fun  in  4  bits [3:2] select the unit (00 arith, 01 logic, 10 cmp, 11 shift); bits [1:0] are the function code.
- cmd_a, cmd_b  in  WIDTH  operands.
- A, B  out  WIDTH  operand buses to the units.
- ALU_FUN  out  2  function code to the units.
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  out  1 each  one-hot unit enables.
- unit_out  in  WIDTH  OR of all unit result registers. Disabled units output 0.
- unit_flag  in  1  OR of all unit flag registers.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  captured result.
- rsp_err  out  1  operation aborted by timeout.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: cmd_ready=1.
  - On cmd_valid && cmd_ready, the sequencer registers cmd_a, cmd_b, cmd_fun and moves to ISSUE.
- ISSUE: lasts one cycle.
  - A and B carry the registered operands; ALU_FUN = fun[1:0].
  - Exactly one enable is high, selected by fun[3:2].
  - Next state is WAIT unconditionally.
- WAIT: all enables are 0. A, B and ALU_FUN hold their values.
  - If unit_flag=1: rsp_data <= unit_out, rsp_err <= 0, go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready=1, then the FSM returns to IDLE.
- cmd_ready is 0 in ISSUE, WAIT and RESP. Exactly one operation is outstanding at a time.
- Enables, A, B, ALU_FUN, rsp_* are registered outputs. cmd_ready is decoded from the state register.
- Results pass through unmodified. No sign extension or width change is applied; signedness is the units' concern.
- Reset takes priority over every state, including mid-operation:
  - The next state is IDLE.
  - A, B, ALU_FUN, all enables, rsp_valid, rsp_data and rsp_err clear to 0.
  - cmd_ready is 1 from the first cycle after reset.
  - Any in-flight operation is dropped with no response.
- unit_flag seen in IDLE, ISSUE or RESP is ignored.

## Timing
- The command is accepted at edge E0. After E0, state is ISSUE and the enable is high. The unit captures at E1, so its flag is visible after E1.
- The sequencer samples the flag at E2; rsp_valid is high after E2. Latency from accept edge to rsp_valid is 2 cycles.
- rsp_ready is sampled in RESP. With rsp_ready held at 1 throughout, the FSM is in IDLE one cycle after rsp_valid rises.
- The next command can therefore be accepted 4 cycles after the previous accept edge.
- The response handshake completes on the edge where rsp_valid && rsp_ready. rsp_valid falls on that edge.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined:
  - A counter is cleared on entering WAIT and increments each WAIT cycle.
  - If unit_flag is still 0 when the count reaches TIMEOUT, the FSM moves to RESP with rsp_data=0 and rsp_err=1.
  - If unit_flag=1 arrives on the same cycle the count reaches TIMEOUT, the flag wins and rsp_err=0.
- ALU_SEQ_TIMEOUT_EN undefined: no counter. WAIT persists until unit_flag=1, and rsp_err is tied to 0.

## Test plan
- Logic AND: cmd_fun=4'b0100, cmd_a=16'hF0F0, cmd_b=16'hFF00, with a logic-unit model attached.
  - Required: Logic_Enable high for exactly 1 cycle with ALU_FUN=2'b00; rsp_valid 2 cycles after accept; rsp_data=16'hF000, rsp_err=0.
- Back-pressure: same command with rsp_ready=0 for 5 cycles after rsp_valid rises.
  - Required: rsp_valid and rsp_data stay stable and cmd_ready stays 0. After rsp_ready=1 the FSM returns to IDLE and cmd_ready=1.
- Back-to-back: NOR (4'b0111, A=16'h00FF, B=16'h0F00), then NAND (4'b0110, A=16'hFFFF, B=16'h00FF), cmd_valid held high, rsp_ready=1.
  - Required: responses 16'hF000 then 16'hFF00, in order; accept edges 4 cycles apart; no command dropped.
- Timeout (macro defined, TIMEOUT=8): command 4'b1000 with no unit responding.
  - Required: CMP_Enable pulses once; rsp_valid rises after 8 WAIT cycles with rsp_err=1, rsp_data=0.
- Reset mid-operation: assert rst for 1 cycle while in WAIT.
  - Required: all outputs are 0 and cmd_ready=1 on the next cycle; no rsp_valid is generated; a following command completes normally.
